// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory port arbiter.
//               - arb_state_t : arbiter ownership state (IDLE / OWN0 / OWN1)
//               - PORT_PIPE   : index of the pipeline MEM-stage requester
//               - PORT_AUX    : index of the secondary (debug/DMA) requester
//               - ADDR_W_DEF / DATA_W_DEF : default bus widths
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_PIPE = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Ownership state that corresponds to a given port index.
    function automatic arb_state_t own_state(input logic id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pick
// Description : Pure-combinational 2-way request picker.
//               Ports:
//                 req[1:0]    in  : per-port request (already reset-gated)
//                 last        in  : port granted most recently
//                 owner_valid in  : a port currently holds the lock
//                 owner_id    in  : index of the lock holder
//                 gnt[1:0]    out : one-hot grant (or zero)
//               Build option DMEM_ARB_RR_EN: when defined, ties go to the port
//               that was not granted last (round-robin); otherwise port 0
//               (pipeline) always wins a tie.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       owner_valid,
    input  logic       owner_id,
    output logic [1:0] gnt
);

    // Port index that wins when both ports request in IDLE.
    logic w_tie_pick;

`ifdef DMEM_ARB_RR_EN
    assign w_tie_pick = ~last;
`else
    logic w_unused_last;
    assign w_unused_last = last;
    assign w_tie_pick    = PORT_PIPE;
`endif

    always_comb begin
        gnt = 2'b00;
        if (owner_valid) begin
            // Locked: only the owner may be granted, the other port waits.
            gnt = owner_id ? {req[1], 1'b0} : {1'b0, req[0]};
        end else if (req == 2'b11) begin
            gnt = w_tie_pick ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule : dmem_arb_pick
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares the single data-memory port between the pipeline MEM
//               stage (port 0) and a secondary master (port 1).
//               Ports:
//                 m0_* / m1_*  : requester command in, gnt/rvalid/rdata out
//                 mem_*        : command to data_memory, mem_rdata returned
//                                one cycle after mem_read
//               Grants and the memory command are combinational from req and
//               registered state. A granted beat with lock=1 keeps ownership
//               until the owner issues a beat (or idles) with lock=0.
//               Build option DMEM_ARB_RR_EN: round-robin tie break (builds the
//               'last' register); undefined gives fixed priority to port 0.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic                  m0_lock,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic                  m1_lock,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_rsp_pend;
    logic       r_rsp_id;
    logic       w_last;

    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_any_gnt;
    logic       w_sel;
    logic       w_sel_we;
    logic       w_sel_lock;

    // Requests are masked while reset is asserted so every output reads 0.
    assign w_req = {m1_req, m0_req} & {2{~rst}};

    dmem_arb_pick u_pick (
        .req         (w_req),
        .last        (w_last),
        .owner_valid (r_state != IDLE),
        .owner_id    (r_state == OWN1),
        .gnt         (w_gnt)
    );

    assign m0_gnt     = w_gnt[0];
    assign m1_gnt     = w_gnt[1];
    assign w_any_gnt  = |w_gnt;
    assign w_sel      = w_gnt[1];
    assign w_sel_we   = w_sel ? m1_we   : m0_we;
    assign w_sel_lock = w_sel ? m1_lock : m0_lock;

    // ---------------------------------------------------------------- command
    assign mem_read  = w_any_gnt & ~w_sel_we;
    assign mem_write = w_any_gnt &  w_sel_we;
    assign mem_addr  = w_any_gnt ? (w_sel ? m1_addr  : m0_addr)  : '0;
    assign mem_wdata = w_any_gnt ? (w_sel ? m1_wdata : m0_wdata) : '0;
    assign mem_wstrb = w_any_gnt ? (w_sel ? m1_wstrb : m0_wstrb) : '0;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_any_gnt && w_sel_lock) begin
                    w_state_nxt = own_state(w_sel);
                end
            end
            // Owner releases either with an unlocked beat or by going idle
            // with lock dropped; idle with lock held keeps ownership.
            OWN0: begin
                if (!m0_lock && (w_gnt[0] || !m0_req)) begin
                    w_state_nxt = IDLE;
                end
            end
            OWN1: begin
                if (!m1_lock && (w_gnt[1] || !m1_req)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rsp_pend <= 1'b0;
            r_rsp_id   <= PORT_PIPE;
        end else begin
            r_state    <= w_state_nxt;
            r_rsp_pend <= mem_read;
            r_rsp_id   <= w_sel;
        end
    end

    // ---------------------------------------------------------------- last
`ifdef DMEM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= PORT_AUX;
        end else if (w_any_gnt) begin
            r_last <= w_sel;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = PORT_AUX;
`endif

    // ---------------------------------------------------------------- response
    assign m0_rvalid = r_rsp_pend & (r_rsp_id == PORT_PIPE);
    assign m1_rvalid = r_rsp_pend & (r_rsp_id == PORT_AUX);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule : dmem_port_arbiter
`default_nettype wire
